// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Width of every data word moved between the core and the array.
    localparam int DATA_W = 32;

    // Responder FSM: wait for a request, burn wait states, then answer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Wait counter width, $clog2(WAIT_STATES+1), kept at least one bit
    // so a zero-wait build still has a legal (unused) counter register.
    function automatic int waitCntWidth(input int waitStates);
        int w;
        w = $clog2(waitStates + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word array with synchronous write and synchronous read.
// No reset: contents survive a responder reset.
module dmem_word_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Enable-gated write port and read register; the read register only
    // moves on a read, so it holds the last loaded word otherwise.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the core's data-memory port: latches one
// request, waits WAIT_STATES cycles, then answers with a one-cycle Ready.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address_DataMem,
    input  logic [DATA_W-1:0] WriteData_DataMem,
    output logic [DATA_W-1:0] ReadData_DataMem,
    output logic              Ready,
    output logic              Stall,
    output logic              AddrError
);

    localparam int WAIT_CNT_W = waitCntWidth(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    dmem_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    reqWrite_q;
    logic                    reqBoth_q;
    logic [31:0]             addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    ready_q;
    logic                    addrErr_q;
    logic                    rdZero_q;

    logic                    curWrite;
    logic                    curBoth;
    logic [31:0]             curAddr;
    logic [DATA_W-1:0]       curData;
    logic                    latchReq;
    logic                    enterResp;
    logic                    inRange;
    logic                    ramWe;
    logic                    ramRe;
    logic [DATA_W-1:0]       ramRdata;

    // Next-state logic. In IDLE the live inputs describe the access (needed
    // when WAIT_STATES is 0 and RESP follows the sampling edge directly);
    // in every other state the latched copy is used, so the core may
    // change its inputs freely while BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latchReq  = 1'b0;
        enterResp = 1'b0;
        curWrite  = reqWrite_q;
        curBoth   = reqBoth_q;
        curAddr   = addr_q;
        curData   = wdata_q;
        case (state_q)
            IDLE: begin
                curWrite = MemWrite;
                curBoth  = MemRead & MemWrite;
                curAddr  = Address_DataMem;
                curData  = WriteData_DataMem;
                if (MemRead | MemWrite) begin
                    latchReq = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Range check uses the full 32-bit address; only afterwards is it
    // truncated to index the array. A write wins when both strobes are high.
    always_comb begin
        inRange = ((curAddr >> ADDR_BITS) == 32'd0);
        ramWe   = ~Reset & enterResp & curWrite & inRange;
        ramRe   = ~Reset & enterResp & ~curWrite & inRange;
    end

    dmem_word_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (curAddr[ADDR_BITS-1:0]),
        .wdata_i (curData),
        .rdata_o (ramRdata)
    );

    // State, request latch and registered response flags. rdZero_q marks
    // that the visible load data is zero (after reset or an out-of-range
    // read) rather than the array read register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reqWrite_q <= 1'b0;
            reqBoth_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            addrErr_q  <= 1'b0;
            rdZero_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= enterResp;
            addrErr_q <= enterResp & (~inRange | curBoth);
            if (latchReq) begin
                reqWrite_q <= MemWrite;
                reqBoth_q  <= MemRead & MemWrite;
                addr_q     <= Address_DataMem;
                wdata_q    <= WriteData_DataMem;
            end
            if (enterResp & ~curWrite) begin
                rdZero_q <= ~inRange;
            end
        end
    end

    // Stall covers the request cycle in IDLE and all of BUSY; it drops in
    // RESP so the core advances on the Ready cycle, and is forced low in reset.
    always_comb begin
        Stall = ~Reset & (((state_q == IDLE) & (MemRead | MemWrite)) |
                          (state_q == BUSY));
    end

    assign ReadData_DataMem = rdZero_q ? '0 : ramRdata;
    assign Ready            = ready_q;
    assign AddrError        = addrErr_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait
// states (A) and one with zero wait states (B) share clock and reset.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        Reset;

    logic        aRead, aWrite;
    logic [31:0] aAddr, aWdata, aRdata;
    logic        aReady, aStall, aErr;

    logic        bRead, bWrite;
    logic [31:0] bAddr, bWdata, bRdata;
    logic        bReady, bStall, bErr;

    int nVectors = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) dutA (
        .clk               (clk),
        .Reset             (Reset),
        .MemRead           (aRead),
        .MemWrite          (aWrite),
        .Address_DataMem   (aAddr),
        .WriteData_DataMem (aWdata),
        .ReadData_DataMem  (aRdata),
        .Ready             (aReady),
        .Stall             (aStall),
        .AddrError         (aErr)
    );

    data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dutB (
        .clk               (clk),
        .Reset             (Reset),
        .MemRead           (bRead),
        .MemWrite          (bWrite),
        .Address_DataMem   (bAddr),
        .WriteData_DataMem (bWdata),
        .ReadData_DataMem  (bRdata),
        .Ready             (bReady),
        .Stall             (bStall),
        .AddrError         (bErr)
    );

    typedef struct {
        int          which;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input int w, input logic rd, input logic wr,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] expData, input logic expErr,
                                   input string name);
        vec_t v;
        v.which = w; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.expData = expData; v.expErr = expErr; v.name = name;
        return v;
    endfunction

    task automatic setIn(input int w, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (w == 0) begin
            aRead = rd; aWrite = wr; aAddr = addr; aWdata = data;
        end else begin
            bRead = rd; bWrite = wr; bAddr = addr; bWdata = data;
        end
    endtask

    function automatic logic [31:0] rdOf(input int w);
        return (w == 0) ? aRdata : bRdata;
    endfunction

    function automatic logic readyOf(input int w);
        return (w == 0) ? aReady : bReady;
    endfunction

    function automatic logic stallOf(input int w);
        return (w == 0) ? aStall : bStall;
    endfunction

    function automatic logic errOf(input int w);
        return (w == 0) ? aErr : bErr;
    endfunction

    // One complete access: present it, let it be sampled, then follow it
    // through the wait states to its Ready cycle.
    task automatic applyStimulus(input vec_t v);
        int ws;
        ws = (v.which == 0) ? 2 : 0;
        @(negedge clk);
        setIn(v.which, v.rd, v.wr, v.addr, v.wdata);
        #1;
        checkOutput({v.name, " stall-request"}, 32'(stallOf(v.which)), 32'd1);
        @(posedge clk);
        #1 setIn(v.which, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= ws + 1; k++) begin
            @(negedge clk);
            if (k <= ws) begin
                checkOutput({v.name, " ready-early"}, 32'(readyOf(v.which)), 32'd0);
                checkOutput({v.name, " stall-busy"}, 32'(stallOf(v.which)), 32'd1);
            end else begin
                checkOutput({v.name, " ready"}, 32'(readyOf(v.which)), 32'd1);
                checkOutput({v.name, " stall-resp"}, 32'(stallOf(v.which)), 32'd0);
                checkOutput({v.name, " addrerr"}, 32'(errOf(v.which)), 32'(v.expErr));
                checkOutput({v.name, " data"}, rdOf(v.which), v.expData);
            end
        end
    endtask

    // Top-level sequence: reset, table of accesses, then multi-cycle corners
    initial begin
        int readies;

        Reset = 1'b1;
        setIn(0, 1'b1, 1'b0, 32'h0, 32'h0);
        setIn(1, 1'b0, 1'b1, 32'h0, 32'h0);
        #3;
        checkOutput("reset A data", aRdata, 32'h0);
        checkOutput("reset A ready", 32'(aReady), 32'd0);
        checkOutput("reset A stall", 32'(aStall), 32'd0);
        checkOutput("reset A addrerr", 32'(aErr), 32'd0);
        checkOutput("reset B data", bRdata, 32'h0);
        checkOutput("reset B stall", 32'(bStall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset A ready held", 32'(aReady), 32'd0);
        checkOutput("reset B ready held", 32'(bReady), 32'd0);
        @(negedge clk);
        setIn(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setIn(1, 1'b0, 1'b0, 32'h0, 32'h0);
        Reset = 1'b0;

        vecs.push_back(mkVec(0, 0, 1, 32'd5,         32'h0BADF00D, 32'h0,        0, "A wr5"));
        vecs.push_back(mkVec(0, 0, 1, 32'd3,         32'h12345678, 32'h0,        0, "A wr3"));
        vecs.push_back(mkVec(0, 1, 0, 32'd3,         32'h0,        32'h12345678, 0, "A rd3"));
        vecs.push_back(mkVec(0, 1, 0, 32'd5,         32'h0,        32'h0BADF00D, 0, "A rd5"));
        vecs.push_back(mkVec(0, 0, 1, 32'd0,         32'hCAFE0000, 32'h0BADF00D, 0, "A wr0"));
        vecs.push_back(mkVec(0, 1, 0, 32'h100,       32'h0,        32'h0,        1, "A rd oor"));
        vecs.push_back(mkVec(0, 0, 1, 32'h100,       32'hFFFFFFFF, 32'h0,        1, "A wr oor"));
        vecs.push_back(mkVec(0, 1, 0, 32'd0,         32'h0,        32'hCAFE0000, 0, "A rd0"));
        vecs.push_back(mkVec(0, 1, 1, 32'd7,         32'h55,       32'hCAFE0000, 1, "A rdwr7"));
        vecs.push_back(mkVec(0, 1, 0, 32'd7,         32'h0,        32'h55,       0, "A rd7"));
        vecs.push_back(mkVec(1, 0, 1, 32'd0,         32'hA,        32'h0,        0, "B wr0"));
        vecs.push_back(mkVec(1, 0, 1, 32'd1,         32'hB,        32'h0,        0, "B wr1"));
        vecs.push_back(mkVec(1, 1, 0, 32'd0,         32'h0,        32'hA,        0, "B rd0"));
        vecs.push_back(mkVec(1, 1, 0, 32'd1,         32'h0,        32'hB,        0, "B rd1"));
        vecs.push_back(mkVec(1, 1, 0, 32'hFFFF0001,  32'h0,        32'h0,        1, "B rd hi-oor"));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset pulse while a write is waiting in BUSY
        @(negedge clk);
        setIn(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        @(posedge clk);
        #1 setIn(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rstmid stall-busy", 32'(aStall), 32'd1);
        #1 Reset = 1'b1;
        #1;
        checkOutput("rstmid data", aRdata, 32'h0);
        checkOutput("rstmid ready", 32'(aReady), 32'd0);
        checkOutput("rstmid stall", 32'(aStall), 32'd0);
        checkOutput("rstmid addrerr", 32'(aErr), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        readies = 0;
        repeat (4) begin
            @(negedge clk);
            if (aReady) readies++;
        end
        checkOutput("rstmid ready-count", 32'(readies), 32'd0);
        applyStimulus(mkVec(0, 1, 0, 32'd5, 32'h0, 32'h0BADF00D, 0, "A rd5 after rst"));

        // Address and data change while BUSY must not affect the access
        applyStimulus(mkVec(0, 0, 1, 32'd10, 32'h33333333, 32'h0BADF00D, 0, "A wr10"));
        @(negedge clk);
        setIn(0, 1'b0, 1'b1, 32'd9, 32'h11111111);
        @(posedge clk);
        #1 setIn(0, 1'b0, 1'b0, 32'd10, 32'h22222222);
        readies = 0;
        repeat (6) begin
            @(negedge clk);
            if (aReady) readies++;
        end
        checkOutput("ignore ready-count", 32'(readies), 32'd1);
        applyStimulus(mkVec(0, 1, 0, 32'd9,  32'h0, 32'h11111111, 0, "A rd9"));
        applyStimulus(mkVec(0, 1, 0, 32'd10, 32'h0, 32'h33333333, 0, "A rd10"));

        // Zero-wait back-to-back reads: Ready every second cycle
        @(negedge clk);
        setIn(1, 1'b1, 1'b0, 32'd0, 32'h0);
        #1;
        checkOutput("b2b stall-req0", 32'(bStall), 32'd1);
        @(negedge clk);
        checkOutput("b2b ready0", 32'(bReady), 32'd1);
        checkOutput("b2b data0", bRdata, 32'hA);
        checkOutput("b2b stall-resp0", 32'(bStall), 32'd0);
        setIn(1, 1'b1, 1'b0, 32'd1, 32'h0);
        @(negedge clk);
        checkOutput("b2b gap ready", 32'(bReady), 32'd0);
        checkOutput("b2b gap stall", 32'(bStall), 32'd1);
        @(negedge clk);
        checkOutput("b2b ready1", 32'(bReady), 32'd1);
        checkOutput("b2b data1", bRdata, 32'hB);
        setIn(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("b2b idle ready", 32'(bReady), 32'd0);
        checkOutput("b2b idle stall", 32'(bStall), 32'd0);
        checkOutput("b2b data hold", bRdata, 32'hB);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the core's data-memory interface. It samples the core's MemRead/MemWrite/Address_DataMem/WriteData_DataMem signals and services each request from an internal word-addressed array after a programmable number of wait states. It returns ReadData_DataMem with a one-cycle Ready pulse. A combinational Stall output lets the core hold PC while a request is outstanding.

Parameters:
ADDR_BITS, 8, word-address width; array depth = 2**ADDR_BITS 32-bit words.
WAIT_STATES, 2, cycles spent in BUSY before the response; 0 is legal.

Ports:
clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  read request from core
MemWrite  input  1  write request from core
Address_DataMem  input  32  word address (not byte address)
WriteData_DataMem  input  32  store data
ReadData_DataMem  output  32  load data, registered
Ready  output  1  one-cycle completion pulse
Stall  output  1  request pending, not yet complete; core must hold PC
AddrError  output  1  one-cycle pulse coincident with Ready for an out-of-range access

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, ReadData_DataMem=0, Ready=0, AddrError=0, wait counter=0, latched request cleared. Stall=0 while Reset is high. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE, at posedge with MemRead|MemWrite=1:
  - Latch the operation, Address_DataMem and WriteData_DataMem.
  - If WAIT_STATES>0: load counter=WAIT_STATES-1 and go to BUSY.
  - If WAIT_STATES=0: go directly to RESP.
- IDLE with no request: remain in IDLE.
- BUSY: decrement the counter each cycle; move to RESP on the edge where the counter is 0. Input changes during BUSY are ignored because the request is already latched.
- Entry into RESP:
  - Write: the array is written on that same edge.
  - Read: ReadData_DataMem is loaded from the array.
  - Ready=1 for exactly one cycle while in RESP. Next state is unconditionally IDLE.
- Latency: Ready is asserted WAIT_STATES+1 cycles after the sampling edge.
- Stall rule: Stall = (state==IDLE & (MemRead|MemWrite)) | state==BUSY. Stall=0 in RESP, so the core advances on the Ready cycle.
- Back-to-back requests: a request still high in the IDLE cycle after RESP starts a new transaction. The minimum per-access period is WAIT_STATES+2 cycles.
- MemRead and MemWrite both high: treated as a write. ReadData_DataMem is unchanged and AddrError=1 with Ready.
- Out of range (Address_DataMem[31:ADDR_BITS] != 0):
  - No array write.
  - A read returns 0.
  - AddrError=1 with Ready.
- ReadData_DataMem holds its last value through writes and idle cycles.
- Reset during BUSY or RESP: return to IDLE immediately. A pending write is discarded (array unchanged), and no Ready is issued.
- Width: the address is truncated to ADDR_BITS for indexing only after the range check.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - WAIT_CNT_W = $clog2(WAIT_STATES+1);
  - the DATA_W=32 constant.
- One sub-module, dmem_word_ram: single-port array with synchronous write and synchronous read, enable-gated, no reset.
- The FSM, counter and error logic stay in the top module.

Test Plan:
- Reset mid-transaction: WAIT_STATES=2; write 32'hDEADBEEF to address 5, and pulse Reset during BUSY. Required: no Ready; a later read of address 5 returns the pre-existing contents; all outputs are 0 during Reset.
- Write then read with wait states: WAIT_STATES=2; write 32'h12345678 to address 3, then read address 3. Required: Ready 3 cycles after each sampling edge, Stall=1 for the 3 cycles before Ready, ReadData=32'h12345678.
- Zero wait states: WAIT_STATES=0; back-to-back reads of addresses 0 and 1 (preloaded 32'hA, 32'hB). Required: each Ready comes 1 cycle after its sampling edge, period 2 cycles, data A then B.
- Out-of-range access: read address 32'h100 with ADDR_BITS=8. Required: ReadData=0 and AddrError=1 together with Ready. A write to 32'h100 must not corrupt address 0.
- Simultaneous read/write: MemRead=MemWrite=1, address 7, data 32'h55. Required: address 7 becomes 32'h55, ReadData unchanged, AddrError=1 with Ready.
- Ignored input change: change Address_DataMem and WriteData_DataMem during BUSY. Required: the originally latched address and data are used, and exactly one Ready is issued.
